// File: rtl/audionet_pkg.sv
// Shared definitions for the audio network path.
//   NUM_CH / SAMPLE_W / FRAME_W / CH_IDX_W : frame geometry (8 x 32-bit slots)
//   state_t                                : frame assembler operating state
package audionet_pkg;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 32;
    localparam int FRAME_W  = NUM_CH * SAMPLE_W;
    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_bitrev.sv
// Combinational sample bit-orderer for the serializer path.
//   din  : incoming sample
//   dout : din bit-reversed when MSB_FIRST=1, otherwise passed through
// The serializer shifts out the LSB of each slot first, so reversing puts
// sample bit 31 on the wire first.
module sample_bitrev
    import audionet_pkg::*;
#(
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] dout
);

    generate
        if (MSB_FIRST) begin : g_rev
            for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_bit
                assign dout[gi] = din[SAMPLE_W-1-gi];
            end
        end else begin : g_pass
            assign dout = din;
        end
    endgenerate

endmodule

// File: rtl/tdm_frame_assembler.sv
// Packs per-channel 32-bit samples into a 256-bit, 8-slot frame for p2tdm.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : low forces OFF and clears everything (soft reset)
//   s_valid/s_ready : sample handshake, s_chan selects the slot, s_sample data
//   frame_tick      : sample-rate strobe; frame appears on the following cycle
//   valid, pdata    : one-cycle frame strobe, slot c at pdata[32c+31:32c]
//   missIncr        : frame emitted with at least one unwritten channel
//   overwriteIncr   : a channel was written twice within one frame period
module tdm_frame_assembler
    import audionet_pkg::*;
#(
    parameter logic MSB_FIRST  = 1'b1,
    parameter logic HOLD_LAST  = 1'b1,
    parameter logic START_FULL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CH_IDX_W-1:0] s_chan,
    input  logic [SAMPLE_W-1:0] s_sample,
    input  logic                frame_tick,
    output logic                valid,
    output logic [FRAME_W-1:0]  pdata,
    output logic                missIncr,
    output logic                overwriteIncr
);

    state_t              state_reg;
    logic [SAMPLE_W-1:0] acc_reg [NUM_CH];
    logic [NUM_CH-1:0]   mask_reg;
    logic [NUM_CH-1:0]   mask_next;
    logic [FRAME_W-1:0]  pdata_reg;
    logic [FRAME_W-1:0]  pdata_next;
    logic                valid_reg;
    logic                miss_reg;
    logic                ovw_reg;

    logic [SAMPLE_W-1:0] sample_ord;
    logic [NUM_CH-1:0]   chan_bit;
    logic                accept;
    logic                emit;

    sample_bitrev #(
        .MSB_FIRST (MSB_FIRST)
    ) u_bitrev (
        .din  (s_sample),
        .dout (sample_ord)
    );

    assign s_ready  = (state_reg != OFF);
    assign accept   = s_valid && s_ready;
    assign chan_bit = {{(NUM_CH-1){1'b0}}, 1'b1} << s_chan;

    // The mask used here is the one registered before this cycle, so a sample
    // landing on the tick cycle can neither fill a slot of this frame nor
    // complete the PRIME mask.
    assign emit = frame_tick &&
                  ((state_reg == RUN) || (state_reg == PRIME && mask_reg == '1));

    // Per-slot merge: written channels take the accumulator, the rest either
    // repeat what was last emitted or go silent.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign pdata_next[gi*SAMPLE_W +: SAMPLE_W] =
                mask_reg[gi] ? acc_reg[gi] :
                (HOLD_LAST ? pdata_reg[gi*SAMPLE_W +: SAMPLE_W] : '0);
        end
    endgenerate

    // A tick-cycle sample opens the next frame's mask rather than this one.
    always_comb begin
        mask_next = mask_reg;
        if (emit) begin
            mask_next = '0;
        end
        if (accept) begin
            mask_next = mask_next | chan_bit;
        end
    end

    always_ff @(posedge clk) begin
        valid_reg <= 1'b0;
        miss_reg  <= 1'b0;
        ovw_reg   <= 1'b0;
        if (rst || !enable) begin
            state_reg <= OFF;
            mask_reg  <= '0;
            pdata_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                OFF: begin
                    state_reg <= START_FULL ? PRIME : RUN;
                end
                PRIME, RUN: begin
                    if (emit) begin
                        valid_reg <= 1'b1;
                        miss_reg  <= (mask_reg != '1);
                        pdata_reg <= pdata_next;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= OFF;
                end
            endcase
            mask_reg <= mask_next;
            if (accept) begin
                acc_reg[s_chan] <= sample_ord;
                // Tick-cycle samples start a fresh frame period.
                ovw_reg <= mask_reg[s_chan] && !frame_tick;
            end
        end
    end

    assign valid         = valid_reg;
    assign pdata         = pdata_reg;
    assign missIncr      = miss_reg;
    assign overwriteIncr = ovw_reg;

endmodule

// File: tb/tb_tdm_frame_assembler.sv
// Scoreboard bench: two assemblers (MSB/HOLD/FULL = 1/1/1 and 0/0/0) share
// one stimulus stream; a frame-level reference model queues expected frames
// and overwrite pulses, and a negedge monitor pops and compares them.
module tb_tdm_frame_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         s_valid = 1'b0;
    logic [2:0]   s_chan = '0;
    logic [31:0]  s_sample = '0;
    logic         frame_tick = 1'b0;

    logic         s_ready_w [2];
    logic         valid_w   [2];
    logic [255:0] pdata_w   [2];
    logic         miss_w    [2];
    logic         ovw_w     [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    tdm_frame_assembler #(.MSB_FIRST(1'b1), .HOLD_LAST(1'b1), .START_FULL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready_w[0]),
        .s_chan(s_chan), .s_sample(s_sample), .frame_tick(frame_tick), .valid(valid_w[0]),
        .pdata(pdata_w[0]), .missIncr(miss_w[0]), .overwriteIncr(ovw_w[0])
    );

    tdm_frame_assembler #(.MSB_FIRST(1'b0), .HOLD_LAST(1'b0), .START_FULL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready_w[1]),
        .s_chan(s_chan), .s_sample(s_sample), .frame_tick(frame_tick), .valid(valid_w[1]),
        .pdata(pdata_w[1]), .missIncr(miss_w[1]), .overwriteIncr(ovw_w[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        int           k;
        int           cyc;
        logic [255:0] pd;
        logic         miss;
    } fexp_t;

    typedef struct {
        int k;
        int cyc;
    } oexp_t;

    fexp_t fq[$];
    oexp_t oq[$];

    // 0 = off, 1 = waiting for a full set, 2 = running
    int          m_mode [2];
    logic [31:0] m_val  [2][8];
    logic [7:0]  m_fill [2];
    logic [31:0] m_out  [2][8];

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [255:0] packed_out(input int k);
        logic [255:0] p;
        for (int c = 0; c < 8; c++) p[c*32 +: 32] = m_out[k][c];
        return p;
    endfunction

    task automatic model_step(input int k);
        bit msbf, hold, full, all, emit;
        logic [31:0] s;
        fexp_t fe;
        oexp_t oe;
        msbf = (k == 0);
        hold = (k == 0);
        full = (k == 0);
        if (rst || !enable) begin
            m_mode[k] = 0;
            m_fill[k] = '0;
            for (int c = 0; c < 8; c++) begin
                m_val[k][c] = '0;
                m_out[k][c] = '0;
            end
            return;
        end
        if (m_mode[k] == 0) begin
            m_mode[k] = full ? 1 : 2;
            return;
        end
        s    = msbf ? rev32(s_sample) : s_sample;
        all  = (m_fill[k] == 8'hFF);
        emit = frame_tick && (m_mode[k] == 2 || all);
        if (emit) begin
            for (int c = 0; c < 8; c++) begin
                if (m_fill[k][c]) m_out[k][c] = m_val[k][c];
                else if (!hold)   m_out[k][c] = '0;
            end
            fe.k = k; fe.cyc = cyc; fe.pd = packed_out(k); fe.miss = !all;
            fq.push_back(fe);
            m_fill[k] = '0;
            m_mode[k] = 2;
        end
        if (s_valid) begin
            if (!frame_tick && m_fill[k][s_chan]) begin
                oe.k = k; oe.cyc = cyc;
                oq.push_back(oe);
            end
            m_val[k][s_chan]  = s;
            m_fill[k][s_chan] = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit got_f [2];
        bit got_o [2];
        fexp_t fe;
        oexp_t oe;
        if (mon_en) begin
            got_f[0] = 0; got_f[1] = 0; got_o[0] = 0; got_o[1] = 0;
            while (fq.size() > 0 && fq[0].cyc <= cyc) begin
                fe = fq.pop_front();
                got_f[fe.k] = 1;
                checks++;
                if (!valid_w[fe.k]) begin
                    errors++;
                    $display("FAIL frame_valid dut=%0d cyc=%0d got valid=%b want 1", fe.k, cyc, valid_w[fe.k]);
                end else if (pdata_w[fe.k] !== fe.pd || miss_w[fe.k] !== fe.miss) begin
                    errors++;
                    $display("FAIL frame_data dut=%0d cyc=%0d got miss=%b pdata=%h want miss=%b pdata=%h",
                             fe.k, cyc, miss_w[fe.k], pdata_w[fe.k], fe.miss, fe.pd);
                end else begin
                    $display("frame dut=%0d cyc=%0d miss=%0d ok", fe.k, cyc, fe.miss);
                end
            end
            while (oq.size() > 0 && oq[0].cyc <= cyc) begin
                oe = oq.pop_front();
                got_o[oe.k] = 1;
                checks++;
                if (ovw_w[oe.k] !== 1'b1) begin
                    errors++;
                    $display("FAIL overwrite_pulse dut=%0d cyc=%0d got %b want 1", oe.k, cyc, ovw_w[oe.k]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (s_ready_w[k] !== (m_mode[k] != 0)) begin
                    errors++;
                    $display("FAIL s_ready dut=%0d cyc=%0d got %b want %b", k, cyc, s_ready_w[k], m_mode[k] != 0);
                end
                checks++;
                if (pdata_w[k] !== packed_out(k)) begin
                    errors++;
                    $display("FAIL pdata_hold dut=%0d cyc=%0d got %h want %h", k, cyc, pdata_w[k], packed_out(k));
                end
                checks++;
                if (!got_f[k] && (valid_w[k] !== 1'b0 || miss_w[k] !== 1'b0)) begin
                    errors++;
                    $display("FAIL spurious_frame dut=%0d cyc=%0d got valid=%b miss=%b want 0/0", k, cyc, valid_w[k], miss_w[k]);
                end
                checks++;
                if (!got_o[k] && ovw_w[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_overwrite dut=%0d cyc=%0d got %b want 0", k, cyc, ovw_w[k]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [31:0] smp);
        s_valid = 1'b1; s_chan = ch; s_sample = smp;
        step();
        s_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        // Reset for two cycles, then enable.
        rst = 1'b1; enable = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0; enable = 1'b1;
        step();
        chk("enable_ready", {31'd0, s_ready_w[0]}, 32'd1);
        chk("enable_valid", {31'd0, valid_w[0]}, 32'd0);
        chk("enable_pdata_zero", {31'd0, |pdata_w[0]}, 32'd0);

        // Full frame with MSB-first ordering.
        for (int c = 0; c < 8; c++) wr(3'(c), 32'(c + 1));
        chk("pre_tick_valid", {31'd0, valid_w[0]}, 32'd0);
        tick();
        chk("full_valid", {31'd0, valid_w[0]}, 32'd1);
        chk("full_bit31", {31'd0, pdata_w[0][31]}, 32'd1);
        chk("full_ch7_bit28", {31'd0, pdata_w[0][32*7+28]}, 32'd1);
        chk("full_miss", {31'd0, miss_w[0]}, 32'd0);
        step();
        chk("valid_one_cycle", {31'd0, valid_w[0]}, 32'd0);

        // Missing channel 3: hold on dut0, zero on dut1.
        for (int c = 0; c < 8; c++) if (c != 3) wr(3'(c), 32'h10 + 32'(c));
        tick();
        chk("hold_ch3", pdata_w[0][127:96], rev32(32'h4));
        chk("hold_miss", {31'd0, miss_w[0]}, 32'd1);
        chk("zero_ch3", pdata_w[1][127:96], 32'd0);

        // Overwrite on channel 5.
        wr(3'd5, 32'hAAAA_0000);
        wr(3'd5, 32'h5555_0000);
        chk("ovw_pulse", {31'd0, ovw_w[0]}, 32'd1);
        step();
        chk("ovw_single", {31'd0, ovw_w[0]}, 32'd0);
        for (int c = 0; c < 8; c++) if (c != 5) wr(3'(c), 32'h20 + 32'(c));
        tick();
        chk("ovw_slot5", pdata_w[0][191:160], rev32(32'h5555_0000));

        // Collision: ch2 accepted on the tick cycle.
        for (int c = 0; c < 8; c++) if (c != 2) wr(3'(c), 32'h30 + 32'(c));
        frame_tick = 1'b1; s_valid = 1'b1; s_chan = 3'd2; s_sample = 32'hC0DE_0002;
        step();
        frame_tick = 1'b0; s_valid = 1'b0;
        chk("coll_slot2_old", pdata_w[0][95:64], rev32(32'h22));
        chk("coll_miss", {31'd0, miss_w[0]}, 32'd1);
        chk("coll_no_ovw", {31'd0, ovw_w[0]}, 32'd0);
        tick();
        chk("coll_slot2_new", pdata_w[0][95:64], rev32(32'hC0DE_0002));
        // Back-to-back ticks.
        tick();
        chk("b2b_miss", {31'd0, miss_w[0]}, 32'd1);

        // PRIME with 7 of 8 channels: no frame.
        enable = 1'b0; step(); enable = 1'b1; step();
        for (int c = 0; c < 7; c++) wr(3'(c), 32'h40 + 32'(c));
        tick();
        chk("prime_7of8_valid", {31'd0, valid_w[0]}, 32'd0);

        // Mid-frame disable, then mid-frame reset.
        for (int c = 0; c < 4; c++) wr(3'(c), 32'h50 + 32'(c));
        enable = 1'b0; step();
        chk("disable_pdata", {31'd0, |pdata_w[0]}, 32'd0);
        enable = 1'b1; step();
        for (int c = 0; c < 4; c++) wr(3'(c), 32'h60 + 32'(c));
        rst = 1'b1; step(); rst = 1'b0;
        chk("reset_pdata", {31'd0, |pdata_w[0]}, 32'd0);
        step();
        tick();
        chk("reprime_valid", {31'd0, valid_w[0]}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 199) != 0);
            s_valid    = ($urandom_range(0, 1) == 1);
            s_chan     = 3'($urandom_range(0, 7));
            s_sample   = $urandom;
            frame_tick = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; enable = 1'b1; s_valid = 1'b0; frame_tick = 1'b0;
        step();
        step();

        checks++;
        if (fq.size() != 0 || oq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d/%0d want 0/0", fq.size(), oq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_frame_assembler.md
Name: tdm_frame_assembler

Overview:
- Collects per-channel 32-bit audio samples from the packet-parsing path and packs them into the 256-bit, 8-channel frame consumed by p2tdm.
- Emits one frame per frame_tick (sample-rate strobe in the clk domain) as a single-cycle valid with pdata.
- Handles missing and duplicate channel writes and bit-orders each sample for the serializer, which transmits pdata[0] first.

Parameters:
- MSB_FIRST, 1, 1 = bit-reverse each sample so sample bit 31 lands at pdata[32c] (DAC sees MSB first); 0 = no reversal.
- HOLD_LAST, 1, 1 = a channel missing at a tick repeats its previous emitted slot value; 0 = missing slot is zero.
- START_FULL, 1, 1 = after enable, no frame is emitted until a tick finds all 8 channels filled; 0 = emit from the first tick.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  block enable; low acts as soft reset
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_chan  in  3  channel index 0..7
- s_sample  in  32  sample data
- frame_tick  in  1  one-cycle frame strobe
- valid  out  1  one-cycle frame valid to p2tdm
- pdata  out  256  frame; channel c occupies [32c+31:32c]
- missIncr  out  1  pulse: a frame was emitted with fewer than 8 channels filled
- overwriteIncr  out  1  pulse: a channel was written twice within one frame period

Behaviour:
- Reset (rst=1 at a clk edge): state=OFF; acc, mask, pdata=0; valid, missIncr, overwriteIncr=0; s_ready=0. Reset mid-frame discards partial data; no frame is emitted.
- States: OFF, PRIME, RUN.
  - OFF: s_ready=0.
  - OFF->PRIME when enable=1 and START_FULL=1.
  - OFF->RUN when enable=1 and START_FULL=0.
  - PRIME->RUN at a tick where the effective mask is 8'hFF.
  - Any state->OFF when enable=0; this clears acc, mask, pdata and all pulses exactly as reset does.
- s_ready = (state != OFF). There is no other backpressure.
- Accept: when a sample is accepted, acc[slot s_chan] <= sample, bit-reversed per MSB_FIRST, and mask[s_chan] <= 1.
  - If mask[s_chan] was already 1, overwriteIncr=1 on the next cycle and the newer sample wins.
- Tick in RUN, or the PRIME tick that completes the mask:
  - Next cycle: valid=1 and pdata = merge of acc for filled channels.
  - Unfilled slots take the previous pdata slot (HOLD_LAST=1) or 0 (HOLD_LAST=0).
  - missIncr = (mask != 8'hFF), at most one pulse per tick.
  - mask clears.
- Tick in PRIME with the mask incomplete: no valid, no missIncr; mask and acc are retained.
- Latency: frame_tick at cycle N -> valid/pdata at N+1. pdata holds until the next emitted frame; valid is high for exactly 1 cycle.
- Sample accepted in the same cycle as a tick:
  - It belongs to the next frame: mask after the tick = only that channel's bit.
  - It is excluded from the frame emitted for this tick.
  - It does not count as an overwrite.
  - In PRIME, this same-cycle sample does not count toward completing the mask at that tick.
- Back-to-back ticks (N, N+1) are legal. The second tick emits with an empty mask, except for any sample accepted on cycle N.
- missIncr and overwriteIncr can pulse in the same cycle.

Decomposition:
- Shared package audionet_pkg holds:
  - NUM_CH=8, SAMPLE_W=32, FRAME_W=256, CH_IDX_W=3
  - the state type {OFF, PRIME, RUN}
- One sub-module, sample_bitrev: combinational 32-bit reverse, parameterized by MSB_FIRST, instantiated on the sample input path.

Test Plan:
- Reset/enable: rst=1 for 2 cycles, then enable=1 with START_FULL=1 -> valid=0, pdata=0, s_ready=1 one cycle after enable.
- Full frame: write ch0..7 = 32'h0000_0001..32'h0000_0008 with MSB_FIRST=1, then tick at N -> valid=1 only at N+1, pdata[31]=1, pdata[32*7+28]=1, missIncr=0.
- Missing channel: second frame writes all channels except ch3 (HOLD_LAST=1) -> ch3 slot equals the previous frame's ch3 value, missIncr=1. Repeat with HOLD_LAST=0 -> slot [127:96]=0.
- Overwrite: write ch5=32'hAAAA_0000, then ch5=32'h5555_0000 before the tick -> overwriteIncr pulses once, emitted slot holds the reversed 32'h5555_0000.
- Tick/accept collision: ch2 accepted on the tick cycle -> ch2 is absent from the frame emitted at N+1 and present in the following frame. PRIME with 7/8 channels filled at a tick -> no valid.
- Mid-frame disable/reset: after 4 channels are written, drop enable (then repeat with rst) -> pdata=0. Re-enable with one tick -> no valid while in PRIME.
